// File: rtl/immgen_pkg.sv
// Shared types and opcode encodings for the RISC-V immediate generator stage.
package immgen_pkg;

    localparam int unsigned IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_t;

    // Major opcode field, instr[6:2]
    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_OPIMM   = 5'b00100;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;
    localparam logic [4:0] OP_OPIMM32 = 5'b00110;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_OP      = 5'b01100;
    localparam logic [4:0] OP_OP32    = 5'b01110;

    // imm is always sign-extended to IMM_MAX_W and masked to the consumer's XLEN
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_t             fmt;
        logic                 illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational format classification and immediate extraction for one instruction.
module imm_decode
    import immgen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0] instr,
    output imm_entry_t  entry
);

    localparam logic [IMM_MAX_W-1:0] IMM_MASK = {IMM_MAX_W{1'b1}} >> (IMM_MAX_W - XLEN);

    logic [IMM_MAX_W-1:0] imm64;
    imm_fmt_t             fmt;
    logic                 illegal;

    always_comb begin
        imm64   = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            unique case (instr[6:2])
                OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM, OP_OPIMM32: begin
                    imm64 = {{52{instr[31]}}, instr[31:20]};
                    fmt   = FMT_I;
                end
                OP_STORE: begin
                    imm64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                    fmt   = FMT_S;
                end
                OP_BRANCH: begin
                    imm64 = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                    fmt   = FMT_B;
                end
                OP_LUI, OP_AUIPC: begin
                    imm64 = {{32{instr[31]}}, instr[31:12], 12'h000};
                    fmt   = FMT_U;
                end
                OP_JAL: begin
                    imm64 = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                    fmt   = FMT_J;
                end
                OP_OP, OP_OP32: begin
                    fmt = FMT_R;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
        entry.imm     = imm64 & IMM_MASK;
        entry.fmt     = fmt;
        entry.illegal = illegal;
    end

endmodule

// File: rtl/immgen_stage.sv
// Registered immediate generator with a 2-entry skid buffer and a saturating
// illegal-opcode counter.
module immgen_stage
    import immgen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    imm_entry_t decEntry;

    logic             outValid;
    logic [XLEN-1:0]  outImm;
    imm_fmt_t         outFmt;
    logic             outIllegal;
    logic             skidValid;
    logic [XLEN-1:0]  skidImm;
    imm_fmt_t         skidFmt;
    logic             skidIllegal;
    logic [CNT_W-1:0] illegalCnt;
    logic             accept;
    logic             xfer;

    imm_decode #(.XLEN(XLEN)) uDecode (
        .instr (in_instr),
        .entry (decEntry)
    );

    // Bits above XLEN are already masked to zero by the decoder
    if (XLEN < IMM_MAX_W) begin : gUnusedHi
        logic unusedHi;
        assign unusedHi = ^decEntry.imm[IMM_MAX_W-1:XLEN];
    end

    assign in_ready = !skidValid && !flush;
    assign accept   = in_valid && in_ready;
    assign xfer     = outValid && out_ready;

    // Skid can only fill while the output is held, and accepts are blocked while
    // skid is full, so the skid-drain and accept branches never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid    <= 1'b0;
            outImm      <= '0;
            outFmt      <= FMT_R;
            outIllegal  <= 1'b0;
            skidValid   <= 1'b0;
            skidImm     <= '0;
            skidFmt     <= FMT_R;
            skidIllegal <= 1'b0;
        end else if (flush) begin
            outValid  <= 1'b0;
            skidValid <= 1'b0;
        end else if (skidValid && xfer) begin
            outImm     <= skidImm;
            outFmt     <= skidFmt;
            outIllegal <= skidIllegal;
            skidValid  <= 1'b0;
        end else if (accept && (!outValid || xfer)) begin
            outValid   <= 1'b1;
            outImm     <= decEntry.imm[XLEN-1:0];
            outFmt     <= decEntry.fmt;
            outIllegal <= decEntry.illegal;
        end else if (accept) begin
            skidValid   <= 1'b1;
            skidImm     <= decEntry.imm[XLEN-1:0];
            skidFmt     <= decEntry.fmt;
            skidIllegal <= decEntry.illegal;
        end else if (xfer) begin
            outValid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegalCnt <= '0;
        end else if (accept && decEntry.illegal && (illegalCnt != CNT_MAX)) begin
            illegalCnt <= illegalCnt + 1'b1;
        end
    end

    assign out_valid     = outValid;
    assign out_imm       = outImm;
    assign out_fmt       = outFmt;
    assign out_illegal   = outIllegal;
    assign illegal_count = illegalCnt;

endmodule

// File: doc/immgen_stage.md
Name: immgen_stage

Overview:
Registered, parametrised RISC-V immediate generator for the decode pipeline. It accepts a full 32-bit instruction over a valid/ready handshake and classifies the format from opcode bits [6:2]. It produces the sign-extended immediate at XLEN bits, plus a format code and an illegal flag. A 2-entry skid buffer sustains one instruction per cycle under backpressure, and a saturating counter records illegal opcodes.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous pipeline flush; drops buffered entries.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept; equals !skid_valid && !flush.
in_instr  in  32  instruction word.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accept.
out_imm  out  XLEN  sign-extended immediate.
out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
out_illegal  out  1  opcode not in the supported set.
illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Decode from in_instr[6:2]:
  - I: 00000, 00100, 11001, 11100, 00110. Immediate is sext(instr[31:20]).
  - S: 01000. Immediate is sext({instr[31:25], instr[11:7]}).
  - B: 11000. Immediate is sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: 01101, 00101. Immediate is sext({instr[31:12], 12'b0}) to XLEN; bits above 31 replicate instr[31].
  - J: 11011. Immediate is sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R: 01100, 01110. Immediate is 0, fmt R, illegal 0.
  - Any other opcode, or instr[1:0] != 2'b11: imm 0, fmt R, illegal 1. Outputs are never X.
- Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Latency: 1 cycle. An instruction accepted in cycle N appears on out_* in cycle N+1 if the output register was empty or transferring in N.
- Skid buffer:
  - If the output register is held (out_valid && !out_ready) and an accept occurs, the decoded entry goes into skid; in_ready drops the next cycle.
  - When the output transfers, skid moves into the output register.
  - Order is strictly preserved. No entry is dropped or duplicated except by flush/reset.
- Simultaneous output transfer and accept with skid empty: the new entry loads the output register directly; throughput is 1/cycle.
- Full case (skid_valid=1): in_ready=0 and in_instr is ignored.
- Empty case: out_valid=0. out_imm, out_fmt and out_illegal hold their last values and carry no meaning.
- flush:
  - The next cycle has out_valid=0 and skid_valid=0.
  - in_ready is forced to 0 during the flush cycle, so no accept occurs.
  - illegal_count is unaffected.
- illegal_count:
  - Increments by 1 on each accept whose decode is illegal.
  - Saturates at 2^CNT_W-1. Never wraps.
  - Cleared only by reset.
- Reset (synchronous, active-high): out_valid=0, skid_valid=0, out_imm=0, out_fmt=0 (R), out_illegal=0, illegal_count=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards both entries; reset dominates flush and handshakes.

Decomposition:
- Package immgen_pkg contains:
  - typedef enum logic [2:0] imm_fmt_t {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}
  - 5-bit opcode localparams: OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM, OP_OPIMM32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_OP32
  - packed struct imm_entry_t {imm, fmt, illegal}
- Sub-module imm_decode: purely combinational, parametrised by XLEN, instr -> imm_entry_t. immgen_stage instantiates it once and holds the handshake, skid and counter logic.

Test Plan:
- XLEN=32, out_ready=1, instr 0x0DB00013 (I) -> the next cycle has out_valid=1, imm=0x000000DB, fmt=1, illegal=0.
- Back-to-back, one per cycle: S-type instr with imm[11:5]=1111001 and imm[4:0]=11011 (opcode 0100011), then 0xFE000EE3 (B), then 0xFF9FF06F (J).
  - Outputs on consecutive cycles: 0xFFFFFF3B/fmt 2, 0xFFFFFFFC/fmt 3, 0xFFFFFFF8/fmt 5.
- XLEN=64, instr 0xFFFFF037 (LUI) -> imm=0xFFFFFFFF_FFFFF000, fmt=4.
- Backpressure: out_ready=0 and send 3 instructions.
  - First goes to out, second to skid, in_ready=0 from the next cycle; the third is held upstream.
  - Raise out_ready: all three emerge in order, no loss.
- Illegal: instr 0x0000007F, and instr 0x00000010 (bits[1:0]=00) -> illegal=1, imm=0, fmt=0.
  - With CNT_W=2, send 5 illegal instructions -> illegal_count reaches 3 and stays 3.
- Flush with both entries full -> the next cycle has out_valid=0 and in_ready=1, and illegal_count is unchanged.
  - Reset asserted mid-stream -> all outputs read as their reset values the next cycle.
